// File: rtl/mem_port_arbiter.sv
// Shares the MIPS core's single-ported unified memory between the instruction-fetch and data-access requesters.
// Each access is multi-cycle, read data returns with a one-cycle ready pulse, and stalls freeze the waiting stage.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_d
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_d;
  logic             gnt_d;
  logic             grant_d_c;

  // Data side wins contention unless it won the previous grant.
  assign grant_d_c = d_req & (~if_req | ~last_d);

  assign stall_if = if_req & ~if_ready;
  assign stall_d  = d_req & ~d_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_d    <= 1'b0;
      gnt_d     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state  <= ACCESS;
            cnt    <= CNT_W'(MEM_LAT - 1);
            mem_en <= 1'b1;
            gnt_d  <= grant_d_c;
            last_d <= grant_d_c;
            if (grant_d_c) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_we    <= d_we;
            end else begin
              mem_addr <= if_addr;
              mem_we   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state  <= DONE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (gnt_d) begin
              // Stores leave the load-data register untouched.
              if (!mem_we) d_rdata <= mem_rdata;
              d_ready <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // Requests are deliberately ignored here; req is still high during the ready cycle.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: one instance at MEM_LAT=2, one at MEM_LAT=1.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // MEM_LAT = 2 instance
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_en, mem_we, stall_if, stall_d;

  // MEM_LAT = 1 instance
  logic        if_req1, d_req1, d_we1;
  logic [31:0] if_addr1, d_addr1, d_wdata1, mem_rdata1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic        if_ready1, d_ready1, mem_en1, mem_we1, stall_if1, stall_d1;

  int passed = 0;
  int total  = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_d(stall_d)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_ready(d_ready1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_d(stall_d1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock edge and settle just after it; cycle k follows the k-th tick.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    if_req1 = 0; d_req1 = 0; d_we1 = 0; if_addr1 = 0; d_addr1 = 0; d_wdata1 = 0; mem_rdata1 = 0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);

    // single fetch, address changes mid-access
    if_req = 1; if_addr = 32'h10;
    #1 chk("f_stall_c0", 32'(stall_if), 32'd1);
    tick();
    chk("f_en_c1", 32'(mem_en), 32'd1);
    chk("f_addr_c1", mem_addr, 32'h10);
    chk("f_we_c1", 32'(mem_we), 32'd0);
    chk("f_stall_c1", 32'(stall_if), 32'd1);
    if_addr = 32'h20;
    tick();
    chk("f_en_c2", 32'(mem_en), 32'd1);
    chk("f_addr_c2", mem_addr, 32'h10);
    chk("f_ready_c2", 32'(if_ready), 32'd0);
    chk("f_stall_c2", 32'(stall_if), 32'd1);
    mem_rdata = 32'h2002000A;
    tick();
    chk("f_en_c3", 32'(mem_en), 32'd0);
    chk("f_ready_c3", 32'(if_ready), 32'd1);
    chk("f_rdata_c3", if_rdata, 32'h2002000A);
    chk("f_stall_c3", 32'(stall_if), 32'd0);
    tick();
    if_req = 0;
    chk("f_ready_c4", 32'(if_ready), 32'd0);
    chk("f_no_regrant_c4", 32'(mem_en), 32'd0);
    tick();
    chk("f_idle_c5", 32'(mem_en), 32'd0);
    chk("f_rdata_hold", if_rdata, 32'h2002000A);

    // store
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; mem_rdata = 32'h12345678;
    #1 chk("s_stall_c0", 32'(stall_d), 32'd1);
    tick();
    chk("s_en_c1", 32'(mem_en), 32'd1);
    chk("s_we_c1", 32'(mem_we), 32'd1);
    chk("s_addr_c1", mem_addr, 32'h40);
    chk("s_wdata_c1", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("s_we_c2", 32'(mem_we), 32'd1);
    chk("s_ready_c2", 32'(d_ready), 32'd0);
    tick();
    chk("s_ready_c3", 32'(d_ready), 32'd1);
    chk("s_we_c3", 32'(mem_we), 32'd0);
    chk("s_en_c3", 32'(mem_en), 32'd0);
    chk("s_rdata_kept", d_rdata, 32'd0);
    chk("s_if_ready_c3", 32'(if_ready), 32'd0);
    tick();
    d_req = 0; d_we = 0;
    chk("s_ready_c4", 32'(d_ready), 32'd0);
    tick();

    // contention from reset: D, I, D, I every 4 cycles
    rst = 1; if_req = 1; d_req = 1; d_we = 0; d_addr = 32'h80; if_addr = 32'h100; mem_rdata = 32'hA5;
    tick();
    rst = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("c_en_%0d", k), 32'(mem_en), 32'((k % 4 == 1) || (k % 4 == 2)));
      chk($sformatf("c_dready_%0d", k), 32'(d_ready), 32'((k == 3) || (k == 11)));
      chk($sformatf("c_iready_%0d", k), 32'(if_ready), 32'((k == 7) || (k == 15)));
      if (k % 4 == 1)
        chk($sformatf("c_addr_%0d", k), mem_addr, (k % 8 == 1) ? 32'h80 : 32'h100);
    end
    if_req = 0; d_req = 0;
    tick();
    chk("c_quiet", 32'(mem_en), 32'd0);

    // reset during a store
    d_req = 1; d_we = 1; d_addr = 32'h48; d_wdata = 32'h11;
    tick();
    chk("r_en_c1", 32'(mem_en), 32'd1);
    chk("r_we_c1", 32'(mem_we), 32'd1);
    rst = 1;
    tick();
    chk("r_en_c2", 32'(mem_en), 32'd0);
    chk("r_we_c2", 32'(mem_we), 32'd0);
    chk("r_ready_c2", 32'(d_ready), 32'd0);
    chk("r_addr_c2", mem_addr, 32'd0);
    rst = 0;
    tick();
    chk("r_regrant_en", 32'(mem_en), 32'd1);
    chk("r_regrant_addr", mem_addr, 32'h48);
    chk("r_ready_c3", 32'(d_ready), 32'd0);
    tick();
    chk("r_we_c4", 32'(mem_we), 32'd1);
    tick();
    chk("r_ready_c5", 32'(d_ready), 32'd1);
    tick();
    d_req = 0; d_we = 0;
    tick();

    // load with MEM_LAT = 1
    d_req1 = 1; d_we1 = 0; d_addr1 = 32'h44; mem_rdata1 = 32'h5;
    tick();
    chk("l1_en_c1", 32'(mem_en1), 32'd1);
    chk("l1_addr_c1", mem_addr1, 32'h44);
    chk("l1_ready_c1", 32'(d_ready1), 32'd0);
    tick();
    chk("l1_en_c2", 32'(mem_en1), 32'd0);
    chk("l1_ready_c2", 32'(d_ready1), 32'd1);
    chk("l1_rdata", d_rdata1, 32'h5);
    tick();
    d_req1 = 0;
    chk("l1_ready_c3", 32'(d_ready1), 32'd0);
    chk("l1_no_regrant", 32'(mem_en1), 32'd0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory of the MIPS core between the instruction-fetch (IF) requester and the data-access (MEM stage) requester.
- Sequences each multi-cycle memory access and returns read data with a one-cycle ready pulse.
- Generates stall signals that freeze the pipeline while a requester waits.
- Sits between the pipeline stages and the memory model, inside the MIPS top level.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, memory access cycles, ≥1; mem_en is held for exactly this many cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- if_req  input  1  fetch request; held until if_ready.
- if_addr  input  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  output  DATA_W  fetched instruction; registered.
- if_ready  output  1  one-cycle completion pulse for fetch.
- d_req  input  1  data request; held until d_ready.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_rdata  output  DATA_W  load data; registered.
- d_ready  output  1  one-cycle completion pulse for data.
- mem_en  output  1  memory access enable.
- mem_we  output  1  memory write enable; high only while mem_en is high.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid in the last mem_en cycle.
- stall_if  output  1  combinational: if_req & ~if_ready.
- stall_d  output  1  combinational: d_req & ~d_ready.

Behaviour:
- Reset values: state IDLE; mem_en, mem_we, if_ready and d_ready all 0; mem_addr, mem_wdata, if_rdata and d_rdata all 0; counter 0; last_d 0.
- FSM states:
  - IDLE: evaluate requests.
  - ACCESS: mem_en = 1; a counter runs MEM_LAT cycles.
  - DONE: one cycle; the granted requester's ready = 1.
- Grant (IDLE, registered at the edge):
  - d_req only -> grant D.
  - if_req only -> grant I.
  - Both high -> grant D unless last_d = 1, in which case grant I. This alternates under contention so neither side starves.
  - last_d is updated on every grant: 1 for D, 0 for I.
- On grant:
  - mem_addr and mem_wdata latch the requester's address and data.
  - mem_we = d_we for a D grant, 0 for an I grant.
  - Next state is ACCESS with the counter loaded to MEM_LAT-1.
- ACCESS:
  - The counter decrements each cycle.
  - When the counter = 0: capture mem_rdata into the granted side's rdata register (loads and fetches only; stores leave d_rdata unchanged), drop mem_en and mem_we, and go to DONE.
- DONE:
  - Assert the granted ready for exactly 1 cycle, then return to IDLE.
  - Requests are not sampled in DONE. The requester's req is still high in that cycle and must not cause a re-grant.
- Timing: with the request seen in IDLE at edge t:
  - mem_en is high for cycles t+1 .. t+MEM_LAT.
  - ready is high in cycle t+MEM_LAT+1.
  - The earliest next grant is at edge t+MEM_LAT+2.
  - Minimum period is MEM_LAT+2 cycles per access.
- Address and data inputs are ignored outside the grant edge. Changes during ACCESS have no effect.
- A request that drops while not granted is simply lost; there is no queueing.
- if_rdata and d_rdata hold their value until the next capture for the same side.
- Reset mid-access (rst high in ACCESS or DONE) at the next edge:
  - Return to IDLE with all outputs at reset values.
  - No ready pulse is issued.
  - A write in progress is abandoned: mem_we drops.

Test Plan:
- Single fetch (MEM_LAT = 2): if_req = 1 with if_addr = 0x10 at edge 0; mem_rdata = 0x2002000A in the last mem_en cycle -> mem_en high in cycles 1–2 with mem_addr = 0x10 and mem_we = 0; if_ready high in cycle 3 only; if_rdata = 0x2002000A; stall_if high in cycles 0–2.
- Store: d_req = 1, d_we = 1, d_addr = 0x40, d_wdata = 0xDEADBEEF -> mem_we = 1 with mem_en in cycles 1–2, mem_wdata = 0xDEADBEEF; d_ready pulses in cycle 3; d_rdata unchanged.
- Contention: if_req and d_req held high continuously from reset -> grant order D, I, D, I; each ready pulses once; accesses start every 4 cycles.
- Load with MEM_LAT = 1: d_req = 1, d_we = 0, d_addr = 0x44, mem_rdata = 0x5 -> mem_en high for 1 cycle; d_ready in the following cycle; d_rdata = 0x5.
- Reset in the middle of ACCESS: rst asserted in the first mem_en cycle of a store -> at the next cycle mem_en = mem_we = 0, state IDLE, no d_ready pulse; after rst deasserts, a held d_req is re-granted normally.
- Address change during ACCESS: if_addr changes from 0x10 to 0x20 in cycle 1 -> mem_addr stays 0x10 through the access.
